// File: rtl/aes_word_loader.sv
// aes_word_loader
//   Front end for a combinational AES-128 encryption core. Collects 32-bit
//   words from a valid/ready stream and assembles the 128-bit key and
//   plaintext. Both are held on the core inputs for SETTLE_CYCLES clocks.
//   The core's ciphertext is then registered and offered downstream over a
//   second valid/ready handshake.
//
//   Optional feature macro: AES_KEY_CACHE_EN
//     defined   : in_key_load (sampled on a frame's first word) selects a
//                 key+data frame (8 words) or a data-only frame (4 words).
//                 The key persists across frames until it is reloaded.
//     undefined : in_key_load is ignored; every frame is 4 key words
//                 followed by 4 data words.
//
//   Ports
//     clk, rst_n   : clock, asynchronous active-low reset
//     in_valid     : upstream word valid
//     in_ready     : loader accepts a word this cycle (registered)
//     in_data      : input word; first word of a group maps to [127:96]
//     in_key_load  : first word of the frame begins a key load
//     core_key     : key register driven to the core
//     core_data    : plaintext register driven to the core
//     core_result  : ciphertext from the core (combinational)
//     out_valid    : ciphertext available
//     out_ready    : downstream accepts the ciphertext
//     out_data     : registered ciphertext
//
//   Parameter
//     SETTLE_CYCLES : cycles the core inputs are held before capture (1..15)

module aes_word_loader #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_key_load,
  output logic [127:0] core_key,
  output logic [127:0] core_data,
  input  logic [127:0] core_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {
    LOAD_KEY,
    LOAD_DATA,
    SETTLE,
    OUTPUT
  } state_e;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_e         state_q, state_d;
  logic           frame_start_q, frame_start_d;
  logic [1:0]     word_cnt_q, word_cnt_d;
  logic [3:0]     settle_cnt_q, settle_cnt_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   out_data_q, out_data_d;
  logic           in_ready_q, in_ready_d;

  logic           key_load;
  logic           accept;
  logic           first_is_key;

`ifdef AES_KEY_CACHE_EN
  assign key_load = in_key_load;
`else
  logic unused_key_load;
  assign unused_key_load = in_key_load;
  assign key_load        = 1'b1;
`endif

  assign accept       = in_valid && in_ready_q;
  assign first_is_key = frame_start_q && key_load;

  // Writes one 32-bit word into the slice selected by idx (0 = MSW).
  function automatic logic [127:0] put_word(input logic [127:0] v,
                                            input logic [1:0]   idx,
                                            input logic [31:0]  w);
    logic [127:0] r;
    r = v;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_DATA;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_DATA: begin
        if (accept) begin
          if (first_is_key) begin
            state_d = LOAD_KEY;
          end else if (word_cnt_q == 2'd3) begin
            state_d = SETTLE;
          end
        end
      end
      LOAD_KEY: begin
        if (accept && word_cnt_q == 2'd3) begin
          state_d = LOAD_DATA;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d = LOAD_DATA;
        end
      end
      default: state_d = LOAD_DATA;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == OUTPUT);
    in_ready  = in_ready_q;
    core_key  = key_q;
    core_data = data_q;
    out_data  = out_data_q;
  end

  // Datapath next-state
  always_comb begin
    frame_start_d = frame_start_q;
    word_cnt_d    = word_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    key_d         = key_q;
    data_d        = data_q;
    out_data_d    = out_data_q;
    // in_ready is registered, so it follows the state being entered; after
    // reset this makes it rise on the first edge rather than immediately.
    in_ready_d    = (state_d == LOAD_KEY) || (state_d == LOAD_DATA);

    case (state_q)
      LOAD_DATA: begin
        if (accept) begin
          frame_start_d = 1'b0;
          if (first_is_key) begin
            key_d      = put_word(key_q, 2'd0, in_data);
            word_cnt_d = 2'd1;
          end else begin
            data_d     = put_word(data_q, word_cnt_q, in_data);
            word_cnt_d = word_cnt_q + 2'd1;
            if (word_cnt_q == 2'd3) begin
              settle_cnt_d = SETTLE_INIT;
            end
          end
        end
      end
      LOAD_KEY: begin
        if (accept) begin
          key_d      = put_word(key_q, word_cnt_q, in_data);
          word_cnt_d = word_cnt_q + 2'd1;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          out_data_d = core_result;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          frame_start_d = 1'b1;
          word_cnt_d    = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q <= 1'b1;
      word_cnt_q    <= '0;
      settle_cnt_q  <= '0;
      key_q         <= '0;
      data_q        <= '0;
      out_data_q    <= '0;
      in_ready_q    <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
      word_cnt_q    <= word_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      key_q         <= key_d;
      data_q        <= data_d;
      out_data_q    <= out_data_d;
      in_ready_q    <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_aes_word_loader.sv
// Testbench for aes_word_loader. Two instances: SETTLE_CYCLES=4 and =1.
// The AES core is stood in for by a table of known FIPS-197 vectors; any
// other key/plaintext pair yields key^data.
module tb_aes_word_loader;

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] D_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_key_load, out_ready, sel;
  logic [31:0] in_data;

  logic         iv0, iv1, ir0, ir1, ov0, ov1, or0, or1;
  logic [127:0] ck0, ck1, cd0, cd1, cr0, cr1, od0, od1;

  logic         in_ready, out_valid;
  logic [127:0] out_data, core_key, core_data;

  int tests = 0;
  int fails = 0;

  function automatic logic [127:0] aes_model(input logic [127:0] k,
                                             input logic [127:0] d);
    if (k == K_C1 && d == D_C1) return C_C1;
    if (k == K_B  && d == D_B)  return C_B;
    return k ^ d;
  endfunction

  assign iv0 = in_valid & ~sel;
  assign iv1 = in_valid &  sel;
  assign or0 = out_ready & ~sel;
  assign or1 = out_ready &  sel;
  assign cr0 = aes_model(ck0, cd0);
  assign cr1 = aes_model(ck1, cd1);

  assign in_ready  = sel ? ir1 : ir0;
  assign out_valid = sel ? ov1 : ov0;
  assign out_data  = sel ? od1 : od0;
  assign core_key  = sel ? ck1 : ck0;
  assign core_data = sel ? cd1 : cd0;

  aes_word_loader #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
    .in_data(in_data), .in_key_load(in_key_load), .core_key(ck0),
    .core_data(cd0), .core_result(cr0), .out_valid(ov0),
    .out_ready(or0), .out_data(od0)
  );

  aes_word_loader #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .in_data(in_data), .in_key_load(in_key_load), .core_key(ck1),
    .core_data(cd1), .core_result(cr1), .out_valid(ov1),
    .out_ready(or1), .out_data(od1)
  );

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send_word(input logic [31:0] w, input logic kl, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_valid    = 1'b1;
    in_data     = w;
    in_key_load = kl;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready wait", 128'(in_ready), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] v, input logic kl, input int gap);
    for (int unsigned i = 0; i < 4; i++) begin
      send_word(v[127-32*i -: 32], kl, gap);
    end
  endtask

  task automatic send_frame(input logic [127:0] k, input logic [127:0] d,
                            input int gap);
    send_block(k, 1'b1, gap);
    send_block(d, 1'b0, gap);
  endtask

  // Waits for out_valid, counting negedges since the last accept edge.
  // With hold=1, also checks the core inputs stay put while settling.
  task automatic wait_out(input string tag, input logic [127:0] exp,
                          input int lat, input logic hold,
                          input logic [127:0] hk, input logic [127:0] hd);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      if (hold) begin
        check({tag, " settle core_data"}, core_data, hd);
        check({tag, " settle core_key"}, core_key, hk);
      end
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 128'(n), 128'(lat));
    check({tag, " out_data"}, out_data, exp);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " in_ready after hs"}, 128'(in_ready), 128'd1);
    check({tag, " out_valid after hs"}, 128'(out_valid), 128'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_key_load = 1'b0; out_ready = 1'b0;
    sel = 1'b0; in_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst out_valid", 128'(out_valid), 128'd0);
    check("rst in_ready", 128'(in_ready), 128'd0);
    check("rst out_data", out_data, '0);
    check("rst core_key", core_key, '0);
    check("rst core_data", core_data, '0);
    rst_n = 1'b1;
    #1 check("in_ready before first edge", 128'(in_ready), 128'd0);
    @(negedge clk);
    check("in_ready after first edge", 128'(in_ready), 128'd1);

    // C.1 back-to-back, then backpressure with a stray in_valid
    send_frame(K_C1, D_C1, 0);
    wait_out("c1", C_C1, 4, 1'b1, K_C1, D_C1);
    in_valid = 1'b1;
    in_data  = 32'hdeadbeef;
    repeat (10) begin
      @(negedge clk);
      check("bp out_valid", 128'(out_valid), 128'd1);
      check("bp out_data", out_data, C_C1);
      check("bp in_ready", 128'(in_ready), 128'd0);
      check("bp core_data", core_data, D_C1);
    end
    in_valid = 1'b0;
    handshake("c1");

    // Key load with a first block, then key reuse
    send_frame(K_B, D_C1, 0);
    wait_out("kb first", K_B ^ D_C1, 4, 1'b0, '0, '0);
    handshake("kb first");
`ifdef AES_KEY_CACHE_EN
    send_block(D_B, 1'b0, 0);
    wait_out("reuse", C_B, 4, 1'b0, '0, '0);
    check("reuse core_key", core_key, K_B);
    handshake("reuse");
`else
    // in_key_load=0 is ignored: the frame is still key then data
    send_block(K_B, 1'b0, 0);
    send_block(D_B, 1'b0, 0);
    wait_out("nocache", C_B, 4, 1'b0, '0, '0);
    handshake("nocache");
`endif

    // Gapped input
    send_frame(K_C1, D_C1, 1);
    wait_out("gap", C_C1, 4, 1'b1, K_C1, D_C1);
    handshake("gap");

    // Reset after 5 words
    send_block(K_C1, 1'b1, 0);
    send_word(D_C1[127:96], 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 128'(out_valid), 128'd0);
    check("midrst in_ready", 128'(in_ready), 128'd0);
    check("midrst core_key", core_key, '0);
    check("midrst core_data", core_data, '0);
    check("midrst out_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post-rst no out_valid", 128'(out_valid), 128'd0);
    end
    send_frame(K_C1, D_C1, 0);
    wait_out("post-rst", C_C1, 4, 1'b0, '0, '0);
    handshake("post-rst");

    // SETTLE_CYCLES=1 instance
    sel = 1'b1;
    send_frame(K_C1, D_C1, 0);
    wait_out("s1", C_C1, 1, 1'b1, K_C1, D_C1);
    handshake("s1");
    sel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_word_loader.md
# aes_word_loader

Front-end stage for the combinational AES-128 encryption core. It accepts 32-bit words over a valid/ready stream and assembles the 128-bit key and plaintext block. It holds both stable on the core's inputs for a programmable multicycle settle window, then registers the core's ciphertext and offers it downstream over a second valid/ready handshake.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: clock cycles the core inputs are held before the result is captured; legal range 1..15.

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- in_valid  in  1: upstream word valid.
- in_ready  out  1: loader accepts a word this cycle.
- in_data  in  32: input word; first word of a group maps to bits [127:96].
- in_key_load  in  1: sampled only on the first word of a frame; 1 means the frame is 4 key words followed by 4 data words.
- core_key  out  128: key register, driven to the core.
- core_data  out  128: plaintext register, driven to the core.
- core_result  in  128: ciphertext from the core (combinational).
- out_valid  out  1: ciphertext available.
- out_ready  in  1: downstream accepts the ciphertext.
- out_data  out  128: registered ciphertext.

## Operation
- States:
  - LOAD_KEY: accepting key words.
  - LOAD_DATA: accepting data words.
  - SETTLE: holding inputs while the core settles.
  - OUTPUT: offering the ciphertext.
  - Reset state is LOAD_DATA with frame_start=1.
- Word accept occurs when in_valid && in_ready. in_ready=1 only in LOAD_KEY and LOAD_DATA.
- Frame start in LOAD_DATA with in_key_load=1:
  - The word is written to key[127:96] and the state moves to LOAD_KEY with word_cnt=1.
  - The remaining 3 key words fill [95:64], [63:32], [31:0].
  - The state then returns to LOAD_DATA with frame_start=0.
- Frame start with in_key_load=0: the word goes to data[127:96]; the stored key is reused.
- word_cnt is 2 bits, wraps 3→0 and selects the destination slice.
- The 4th data word is accepted on edge N:
  - Enter SETTLE.
  - settle_cnt loads SETTLE_CYCLES-1.
- In SETTLE:
  - settle_cnt decrements each cycle.
  - When settle_cnt==0, out_data<=core_result and the state moves to OUTPUT.
- In OUTPUT, out_valid=1. On out_ready, go to LOAD_DATA with frame_start=1.
- core_key and core_data change only on accepted words; they are stable throughout SETTLE and OUTPUT.
- The next frame's words overwrite data slices in place. Data words of a new frame do not touch key.
- Mid-frame in_key_load changes are ignored.

## Timing
- Reset (rst_n low, asynchronous):
  - state=LOAD_DATA, frame_start=1, word_cnt=0, settle_cnt=0.
  - key=0, data=0, out_data=0.
  - out_valid=0, in_ready=0.
  - in_ready is a register; it goes to 1 on the first rising edge after rst_n deasserts.
- Throughput: 1 word per cycle while in_valid=1.
- Latency: out_valid rises exactly SETTLE_CYCLES edges after edge N.
- out_valid and out_data hold until out_ready is sampled high.
- in_ready rises on the edge after the output handshake. There is no overlap between output and loading.
- in_valid while in_ready=0 is ignored (no accept); upstream must hold the word.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-frame or mid-SETTLE discards the partial frame; no out_valid is produced for it.

## Configuration
- AES_KEY_CACHE_EN defined:
  - in_key_load is honoured.
  - The key persists across frames until reloaded.
  - A data-only frame after reset encrypts with the all-zero key.
- AES_KEY_CACHE_EN undefined:
  - in_key_load is ignored and treated as 1.
  - Every frame is 8 words (key then data).

## Test plan
- FIPS-197 C.1, key frame:
  - Stimulus: key words 00010203 04050607 08090a0b 0c0d0e0f, then data 00112233 44556677 8899aabb ccddeeff, back-to-back.
  - Response: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly SETTLE_CYCLES cycles after the last word.
- Key reuse (AES_KEY_CACHE_EN):
  - Stimulus: load key 2b7e151628aed2a6abf7158809cf4f3c with a first block, then a data-only frame 3243f6a8 885a308d 313198a2 e0370734.
  - Response: 3925841d02dc09fbdc118597196a0b32.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles.
  - Response: out_valid and out_data remain constant; in_ready=0 throughout; in_ready=1 one cycle after out_ready.
- Gapped input:
  - Stimulus: in_valid toggles every other cycle across the C.1 frame.
  - Response: same ciphertext; core_data is unchanged during SETTLE.
- Reset mid-frame:
  - Stimulus: assert rst_n low after 5 words.
  - Response: all outputs are 0 immediately; no out_valid; a full C.1 frame after release gives the correct ciphertext.
- SETTLE_CYCLES=1:
  - Stimulus: run the C.1 frame.
  - Response: out_valid is asserted on the cycle following the last-word accept edge.
